// File: rtl/noc_link_port.sv
// rtl/noc_link_port.sv - NoC mesh edge endpoint: credit-gated TX, B-deep RX FIFO with credit return
module noc_link_port #(
  parameter int FW = 36,
  parameter int B  = 4,
  localparam int CW = $clog2(B + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [FW-1:0] tx_flit,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [FW-1:0] noc_flit_in,
  output logic          noc_flit_in_wr,
  input  logic          noc_credit_out,
  input  logic [FW-1:0] noc_flit_out,
  input  logic          noc_flit_out_wr,
  output logic          noc_credit_in,
  output logic [FW-1:0] rx_flit,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CW-1:0] tx_credits,
  output logic [CW-1:0] rx_count,
  output logic          err_credit,
  output logic          err_overflow
);

  localparam int AW = $clog2(B);
  localparam logic [CW-1:0] DEPTH = CW'(B);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [CW-1:0] tx_credits_q, tx_credits_d;
  logic [FW-1:0] noc_flit_in_q, noc_flit_in_d;
  logic          noc_flit_in_wr_q, noc_flit_in_wr_d;
  logic          err_credit_q, err_credit_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] rx_count_q, rx_count_d;
  logic          noc_credit_in_q, noc_credit_in_d;
  logic          err_overflow_q, err_overflow_d;
  logic [FW-1:0] mem_q [B];

  logic send, push, pop, rx_full;

  // TX credit accounting and registered flit launch into the NoC
  always_comb begin
    tx_ready         = (tx_credits_q != '0);
    send             = tx_valid & tx_ready;
    tx_credits_d     = tx_credits_q;
    err_credit_d     = err_credit_q;
    if (send && !noc_credit_out) begin
      tx_credits_d = tx_credits_q - CNT_ONE;
    end else if (!send && noc_credit_out) begin
      // A credit beyond the router's buffer depth is a protocol error; saturate.
      if (tx_credits_q == DEPTH) err_credit_d = 1'b1;
      else                       tx_credits_d = tx_credits_q + CNT_ONE;
    end
    noc_flit_in_wr_d = send;
    noc_flit_in_d    = send ? tx_flit : noc_flit_in_q;
  end

  // RX FIFO bookkeeping; overflow is judged on the registered count, so a same-cycle pop never rescues a push
  always_comb begin
    rx_full         = (rx_count_q == DEPTH);
    rx_valid        = (rx_count_q != '0);
    push            = noc_flit_out_wr & ~rx_full;
    pop             = rx_valid & rx_ready;
    err_overflow_d  = err_overflow_q | (noc_flit_out_wr & rx_full);
    wr_ptr_d        = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rx_count_d      = rx_count_q;
    if (push && !pop)      rx_count_d = rx_count_q + CNT_ONE;
    else if (!push && pop) rx_count_d = rx_count_q - CNT_ONE;
    noc_credit_in_d = pop;
  end

  // State registers; reset discards all in-flight state without emitting credits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_credits_q     <= DEPTH;
      noc_flit_in_q    <= '0;
      noc_flit_in_wr_q <= 1'b0;
      err_credit_q     <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      rx_count_q       <= '0;
      noc_credit_in_q  <= 1'b0;
      err_overflow_q   <= 1'b0;
    end else begin
      tx_credits_q     <= tx_credits_d;
      noc_flit_in_q    <= noc_flit_in_d;
      noc_flit_in_wr_q <= noc_flit_in_wr_d;
      err_credit_q     <= err_credit_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      rx_count_q       <= rx_count_d;
      noc_credit_in_q  <= noc_credit_in_d;
      err_overflow_q   <= err_overflow_d;
    end
  end

  // FIFO storage needs no reset: entries are only observed once the count covers them
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= noc_flit_out;
  end

  assign rx_flit        = mem_q[rd_ptr_q];
  assign tx_credits     = tx_credits_q;
  assign rx_count       = rx_count_q;
  assign noc_flit_in    = noc_flit_in_q;
  assign noc_flit_in_wr = noc_flit_in_wr_q;
  assign noc_credit_in  = noc_credit_in_q;
  assign err_credit     = err_credit_q;
  assign err_overflow   = err_overflow_q;

endmodule

// File: tb/tb_noc_link_port.sv
// tb/tb_noc_link_port.sv - self-checking bench for noc_link_port with a queue-based reference model
module tb_noc_link_port;

  localparam int FW = 36;
  localparam int B  = 4;
  localparam int CW = $clog2(B + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] tx_flit = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [FW-1:0] noc_flit_in;
  logic          noc_flit_in_wr;
  logic          noc_credit_out = 1'b0;
  logic [FW-1:0] noc_flit_out = '0;
  logic          noc_flit_out_wr = 1'b0;
  logic          noc_credit_in;
  logic [FW-1:0] rx_flit;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [CW-1:0] tx_credits;
  logic [CW-1:0] rx_count;
  logic          err_credit;
  logic          err_overflow;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  noc_link_port #(.FW(FW), .B(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .noc_flit_in(noc_flit_in), .noc_flit_in_wr(noc_flit_in_wr),
    .noc_credit_out(noc_credit_out),
    .noc_flit_out(noc_flit_out), .noc_flit_out_wr(noc_flit_out_wr),
    .noc_credit_in(noc_credit_in),
    .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_credits(tx_credits), .rx_count(rx_count),
    .err_credit(err_credit), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer credit count, a queue for the RX FIFO, sticky flags
  int            m_cred = B;
  logic          m_wr = 1'b0;
  logic [FW-1:0] m_flit = '0;
  logic          m_cin = 1'b0;
  logic          m_ecred = 1'b0;
  logic          m_eovf = 1'b0;
  logic [FW-1:0] rxq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cred = B; m_wr = 1'b0; m_flit = '0; m_cin = 1'b0;
      m_ecred = 1'b0; m_eovf = 1'b0; rxq.delete();
    end else begin
      bit snd, was_full, do_pop;
      snd = tx_valid && (m_cred != 0);
      if (snd && !noc_credit_out) m_cred = m_cred - 1;
      else if (!snd && noc_credit_out) begin
        if (m_cred == B) m_ecred = 1'b1;
        else m_cred = m_cred + 1;
      end
      m_wr = snd;
      if (snd) m_flit = tx_flit;
      was_full = (rxq.size() == B);
      do_pop = rx_ready && (rxq.size() != 0);
      m_cin = do_pop;
      if (do_pop) void'(rxq.pop_front());
      if (noc_flit_out_wr) begin
        if (was_full) m_eovf = 1'b1;
        else rxq.push_back(noc_flit_out);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("tx_ready", 64'(tx_ready), 64'(m_cred != 0));
      chk("tx_credits", 64'(tx_credits), 64'(m_cred));
      chk("noc_flit_in_wr", 64'(noc_flit_in_wr), 64'(m_wr));
      chk("noc_flit_in", 64'(noc_flit_in), 64'(m_flit));
      chk("noc_credit_in", 64'(noc_credit_in), 64'(m_cin));
      chk("rx_valid", 64'(rx_valid), 64'(rxq.size() != 0));
      chk("rx_count", 64'(rx_count), 64'(rxq.size()));
      if (rxq.size() != 0) chk("rx_flit", 64'(rx_flit), 64'(rxq[0]));
      chk("err_credit", 64'(err_credit), 64'(m_ecred));
      chk("err_overflow", 64'(err_overflow), 64'(m_eovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    tx_valid = 1'b0; noc_credit_out = 1'b0; noc_flit_out_wr = 1'b0; rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst tx_credits", 64'(tx_credits), 64'd4);
    chk("rst tx_ready", 64'(tx_ready), 64'd1);
    chk("rst rx_valid", 64'(rx_valid), 64'd0);
    chk("rst noc_flit_in_wr", 64'(noc_flit_in_wr), 64'd0);
    chk("rst noc_credit_in", 64'(noc_credit_in), 64'd0);
    chk("rst err_credit", 64'(err_credit), 64'd0);
    chk("rst err_overflow", 64'(err_overflow), 64'd0);
    idle();
    step();
    rst_n = 1'b1;
  endtask

  int pulses;

  initial begin
    idle();
    step();
    run_cmp = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    // Credit exhaustion: five back-to-back sends with no credit return
    for (int i = 1; i <= 5; i++) begin
      tx_flit = FW'(i); tx_valid = 1'b1;
      step();
      if (i <= 4) begin
        chk("exh wr", 64'(noc_flit_in_wr), 64'd1);
        chk("exh data", 64'(noc_flit_in), 64'(i));
      end
    end
    chk("exh ready", 64'(tx_ready), 64'd0);
    chk("exh credits", 64'(tx_credits), 64'd0);
    chk("exh 5th held", 64'(noc_flit_in_wr), 64'd0);
    noc_credit_out = 1'b1;
    step();
    noc_credit_out = 1'b0;
    chk("credit back ready", 64'(tx_ready), 64'd1);
    step();
    chk("5th sent wr", 64'(noc_flit_in_wr), 64'd1);
    chk("5th sent data", 64'(noc_flit_in), 64'd5);
    tx_valid = 1'b0;

    // Simultaneous send and credit at two credits, then an excess credit
    noc_credit_out = 1'b1;
    step(); step();
    tx_valid = 1'b1; tx_flit = FW'(36'h0abc);
    step();
    chk("send+credit", 64'(tx_credits), 64'd2);
    tx_valid = 1'b0;
    step(); step();
    chk("credits full", 64'(tx_credits), 64'd4);
    step();
    noc_credit_out = 1'b0;
    chk("excess hold", 64'(tx_credits), 64'd4);
    chk("err_credit set", 64'(err_credit), 64'd1);

    // RX order and credit return
    for (int i = 1; i <= 3; i++) begin
      noc_flit_out = FW'(i); noc_flit_out_wr = 1'b1;
      step();
    end
    noc_flit_out_wr = 1'b0;
    chk("rx count3", 64'(rx_count), 64'd3);
    chk("rx head", 64'(rx_flit), 64'd1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("rx order", 64'(rx_flit), 64'(i));
      step();
      chk("rx credit pulse", 64'(noc_credit_in), 64'd1);
    end
    rx_ready = 1'b0;
    step();
    chk("rx credit end", 64'(noc_credit_in), 64'd0);
    chk("rx empty", 64'(rx_count), 64'd0);

    // RX overflow: fifth push dropped
    for (int i = 0; i < 5; i++) begin
      noc_flit_out = FW'(16 + i); noc_flit_out_wr = 1'b1;
      step();
    end
    noc_flit_out_wr = 1'b0;
    chk("ovf count", 64'(rx_count), 64'd4);
    chk("ovf flag", 64'(err_overflow), 64'd1);
    chk("ovf head", 64'(rx_flit), 64'h10);
    rx_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (noc_credit_in) pulses++;
    end
    rx_ready = 1'b0;
    chk("ovf drain credits", 64'(pulses), 64'd4);

    // Mid-stream reset, then wrap-around streaming
    tx_valid = 1'b1; noc_flit_out_wr = 1'b1; noc_flit_out = FW'(36'h77);
    step();
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      noc_flit_out = FW'(256 + i); noc_flit_out_wr = 1'b1; rx_ready = 1'b1;
      step();
      if (noc_credit_in) pulses++;
      chk("wrap count<=1", 64'(rx_count <= CW'(1)), 64'd1);
    end
    noc_flit_out_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (noc_credit_in) pulses++;
    end
    rx_ready = 1'b0;
    chk("wrap credits", 64'(pulses), 64'd20);
    chk("wrap err_credit", 64'(err_credit), 64'd0);
    chk("wrap err_overflow", 64'(err_overflow), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tx_valid        = ($urandom_range(0, 3) != 0);
      tx_flit         = FW'({$urandom(), $urandom()});
      noc_credit_out  = ($urandom_range(0, 2) == 0);
      noc_flit_out_wr = ($urandom_range(0, 1) == 0);
      noc_flit_out    = FW'({$urandom(), $urandom()});
      rx_ready        = ($urandom_range(0, 2) != 0);
      if (i == 1500) do_reset();
      else step();
    end
    idle();
    step();
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
